// File: rtl/cache_line_writeback.sv
// Captures an evicted cache line and, when dirty, streams it to memory one word
// per valid/ready beat, lowest word first, then pulses done.
module cache_line_writeback #(
   parameter int LINE_BITS = 256,
   parameter int WORD_BITS = 32,
   parameter int ADDR_BITS = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 dirty,
   input  logic [ADDR_BITS-1:0] line_addr,
   input  logic [LINE_BITS-1:0] line_data,
   output logic                 mem_valid,
   input  logic                 mem_ready,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [WORD_BITS-1:0] mem_data,
   output logic                 busy,
   output logic                 done
);

   localparam int BEATS      = LINE_BITS / WORD_BITS;
   localparam int BEAT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WORD_BYTES = WORD_BITS / 8;
   localparam int LINE_BYTES = LINE_BITS / 8;

   localparam logic [BEAT_BITS-1:0] LAST_BEAT  = BEAT_BITS'(BEATS - 1);
   localparam logic [ADDR_BITS-1:0] ADDR_STEP  = ADDR_BITS'(WORD_BYTES);
   localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~ADDR_BITS'(LINE_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state, next_state;
   logic [BEAT_BITS-1:0] beat, next_beat;
   logic [LINE_BITS-1:0] line, next_line;
   logic                 next_valid, next_busy, next_done;
   logic [ADDR_BITS-1:0] next_addr;
   logic [WORD_BITS-1:0] next_data;

   // Every output is computed one cycle ahead and registered, so nothing on the
   // input side reaches an output combinationally.
   always_comb begin
      next_state = state;
      next_beat  = beat;
      next_line  = line;
      next_valid = mem_valid;
      next_addr  = mem_addr;
      next_data  = mem_data;
      next_busy  = busy;
      next_done  = 1'b0;

      unique case (state)
         IDLE: begin
            if (start && dirty) begin
               next_line  = line_data;
               next_beat  = '0;
               next_valid = 1'b1;
               next_addr  = line_addr & ALIGN_MASK;
               next_data  = line_data[WORD_BITS-1:0];
               next_busy  = 1'b1;
               next_state = SEND;
            end else if (start) begin
               next_done  = 1'b1;
               next_busy  = 1'b1;
               next_state = DONE;
            end
         end
         SEND: begin
            if (mem_ready) begin
               if (beat == LAST_BEAT) begin
                  next_valid = 1'b0;
                  next_done  = 1'b1;
                  next_state = DONE;
               end else begin
                  next_beat = beat + BEAT_BITS'(1);
                  next_addr = mem_addr + ADDR_STEP;
                  next_data = line[int'(next_beat) * WORD_BITS +: WORD_BITS];
               end
            end
         end
         DONE: begin
            next_busy  = 1'b0;
            next_state = IDLE;
         end
         default: begin
            next_valid = 1'b0;
            next_busy  = 1'b0;
            next_state = IDLE;
         end
      endcase
   end

   // Reset abandons any transaction in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         beat      <= '0;
         line      <= '0;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= next_state;
         beat      <= next_beat;
         line      <= next_line;
         mem_valid <= next_valid;
         mem_addr  <= next_addr;
         mem_data  <= next_data;
         busy      <= next_busy;
         done      <= next_done;
      end
   end

endmodule

// File: tb/tb_cache_line_writeback.sv
// Directed bench for cache_line_writeback: full writeback, stalls, clean evictions,
// ignored requests while busy, mid-transfer reset and back-to-back evictions.
module tb_cache_line_writeback;

   logic         clk;
   logic         reset;
   logic         start;
   logic         dirty;
   logic [31:0]  line_addr;
   logic [255:0] line_data;
   logic         mem_valid;
   logic         mem_ready;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_data;
   logic         busy;
   logic         done;

   int           checks = 0;
   int           errors = 0;
   logic [255:0] line_a;

   cache_line_writeback dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dirty     (dirty),
      .line_addr (line_addr),
      .line_data (line_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled and inputs driven 1 ns after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic s, input logic d, input logic [31:0] a,
                                 input logic [255:0] data, input logic rdy);
      start     = s;
      dirty     = d;
      line_addr = a;
      line_data = data;
      mem_ready = rdy;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Word k of the reference line, whose byte i holds the value i.
   function automatic logic [31:0] ref_word(input int k);
      return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
   endfunction

   // Dirty eviction with mem_ready held high; optionally re-requests at one beat.
   task automatic run_dirty(input logic [31:0] addr_in, input logic [31:0] exp_base,
                            input int disturb_beat);
      apply_stimulus(1'b1, 1'b1, addr_in, line_a, 1'b1);
      tick();
      for (int k = 0; k < 8; k++) begin
         if (k == disturb_beat)
            apply_stimulus(1'b1, 1'b1, 32'hDEAD_BE00, ~line_a, 1'b1);
         else
            apply_stimulus(1'b0, 1'b0, 32'h0, ~line_a, 1'b1);
         check_output($sformatf("valid beat%0d", k), 32'(mem_valid), 32'd1);
         check_output($sformatf("addr beat%0d", k), mem_addr, exp_base + 32'(4*k));
         check_output($sformatf("data beat%0d", k), mem_data, ref_word(k));
         check_output($sformatf("busy beat%0d", k), 32'(busy), 32'd1);
         check_output($sformatf("done beat%0d", k), 32'(done), 32'd0);
         tick();
      end
      apply_stimulus(1'b0, 1'b0, 32'h0, '0, 1'b1);
      check_output("done pulse", 32'(done), 32'd1);
      check_output("valid after last", 32'(mem_valid), 32'd0);
      check_output("busy at done", 32'(busy), 32'd1);
      tick();
      check_output("done cleared", 32'(done), 32'd0);
      check_output("busy cleared", 32'(busy), 32'd0);
      check_output("valid idle", 32'(mem_valid), 32'd0);
   endtask

   initial begin
      int xfer;
      logic rdy;

      for (int i = 0; i < 32; i++) line_a[8*i +: 8] = 8'(i);

      reset = 1'b1;
      apply_stimulus(1'b0, 1'b0, 32'h0, '0, 1'b0);
      tick();
      tick();
      check_output("reset valid", 32'(mem_valid), 32'd0);
      check_output("reset addr", mem_addr, 32'h0);
      check_output("reset data", mem_data, 32'h0);
      check_output("reset busy", 32'(busy), 32'd0);
      check_output("reset done", 32'(done), 32'd0);
      reset = 1'b0;
      tick();

      $display("[TB] full writeback, ready held high");
      run_dirty(32'h0000_1234, 32'h0000_1220, -1);

      $display("[TB] writeback with ready pattern 1,0,0");
      apply_stimulus(1'b1, 1'b1, 32'h0000_1234, line_a, 1'b0);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0, '0, 1'b0);
      xfer = 0;
      for (int cyc = 0; cyc < 64 && xfer < 8; cyc++) begin
         rdy = (cyc % 3 == 0);
         mem_ready = rdy;
         check_output($sformatf("stall valid c%0d", cyc), 32'(mem_valid), 32'd1);
         check_output($sformatf("stall addr c%0d", cyc), mem_addr, 32'h0000_1220 + 32'(4*xfer));
         check_output($sformatf("stall data c%0d", cyc), mem_data, ref_word(xfer));
         check_output($sformatf("stall done c%0d", cyc), 32'(done), 32'd0);
         if (rdy) xfer++;
         tick();
      end
      mem_ready = 1'b0;
      check_output("stall transfer count", 32'(xfer), 32'd8);
      check_output("stall done pulse", 32'(done), 32'd1);
      check_output("stall valid after last", 32'(mem_valid), 32'd0);
      tick();
      check_output("stall done cleared", 32'(done), 32'd0);
      check_output("stall busy cleared", 32'(busy), 32'd0);

      $display("[TB] clean eviction");
      apply_stimulus(1'b1, 1'b0, 32'h0000_4000, line_a, 1'b1);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0, '0, 1'b1);
      check_output("clean done", 32'(done), 32'd1);
      check_output("clean busy", 32'(busy), 32'd1);
      check_output("clean valid c1", 32'(mem_valid), 32'd0);
      tick();
      check_output("clean done cleared", 32'(done), 32'd0);
      check_output("clean busy cleared", 32'(busy), 32'd0);
      check_output("clean valid c2", 32'(mem_valid), 32'd0);

      $display("[TB] request during beat 3 is ignored");
      run_dirty(32'h0000_1234, 32'h0000_1220, 3);

      $display("[TB] reset during beat 5");
      apply_stimulus(1'b1, 1'b1, 32'h0000_1234, line_a, 1'b1);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0, '0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         check_output($sformatf("pre-reset data beat%0d", k), mem_data, ref_word(k));
         if (k < 5) tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_output("abort valid", 32'(mem_valid), 32'd0);
      check_output("abort busy", 32'(busy), 32'd0);
      check_output("abort addr", mem_addr, 32'h0);
      check_output("abort data", mem_data, 32'h0);
      check_output("abort done", 32'(done), 32'd0);
      tick();
      check_output("abort done later", 32'(done), 32'd0);
      check_output("abort idle valid", 32'(mem_valid), 32'd0);
      run_dirty(32'h0000_1234, 32'h0000_1220, -1);

      $display("[TB] back-to-back evictions at top of address space");
      run_dirty(32'h0000_1234, 32'h0000_1220, -1);
      run_dirty(32'hFFFF_FFE0, 32'hFFFF_FFE0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
